// File: rtl/sr_calc_ctrl_if.sv
// sr_calc_ctrl_if: pipeline/calculator bundle for the calculator sequencer.
// Signal names are given from the controller's point of view:
//   i_req        decoded calculator instruction in the fetch slot
//   i_a_in/b_in  8-bit operands A and B
//   i_rd_in      destination register of the requesting instruction
//   i_calc_busy  calculator busy flag
//   i_calc_y     24-bit calculator result
//   o_calc_a/b   operands held for the calculator
//   o_calc_start one-cycle start pulse
//   o_stall      PC hold (PC write enable = ~o_stall)
//   o_wb_we      register-file write enable
//   o_wb_rd      write-back register address
//   o_wb_data    write-back data
//   o_calc_err   sticky timeout flag
// slave = controller side, master = pipeline/calculator side.
interface sr_calc_ctrl_if;
    logic        i_req;
    logic [7:0]  i_a_in;
    logic [7:0]  i_b_in;
    logic [4:0]  i_rd_in;
    logic        i_calc_busy;
    logic [23:0] i_calc_y;
    logic [7:0]  o_calc_a;
    logic [7:0]  o_calc_b;
    logic        o_calc_start;
    logic        o_stall;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_calc_err;
    modport slave (
        input  i_req, i_a_in, i_b_in, i_rd_in, i_calc_busy, i_calc_y,
        output o_calc_a, o_calc_b, o_calc_start, o_stall, o_wb_we, o_wb_rd, o_wb_data, o_calc_err
    );
    modport master (
        output i_req, i_a_in, i_b_in, i_rd_in, i_calc_busy, i_calc_y,
        input  o_calc_a, o_calc_b, o_calc_start, o_stall, o_wb_we, o_wb_rd, o_wb_data, o_calc_err
    );
endinterface

// File: rtl/sr_calc_ctrl.sv
// sr_calc_ctrl: sequences one calculator operation per request and writes the result back.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sr_calc_ctrl_if.slave (request, operands, calculator handshake, write-back)
// Parameter TIMEOUT_CYCLES (2..65535): WAIT cycles allowed before abort.
// Optional macro SR_CALC_TIMEOUT_EN enables the WAIT timeout and the sticky calc_err flag;
// without it calc_err is tied low and WAIT only exits on completion.
module sr_calc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic           clk,
    input logic           rst_n,
    sr_calc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        r_busy_seen;
    logic        w_done;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    // Completion only counts once busy has been observed, so a calculator
    // that never raises busy cannot retire early.
    assign w_done = r_busy_seen && !bus.i_calc_busy;

`ifdef SR_CALC_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_err;
    assign w_timeout = !w_done && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    // Counter is held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == WAIT) ? r_cnt + 16'd1 : '0;
            if (r_state == WAIT && w_timeout) r_err <= 1'b1;
        end
    end
    assign bus.o_calc_err = r_err;
`else
    assign w_timeout      = 1'b0;
    assign bus.o_calc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_data      <= '0;
            r_busy_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.i_req) begin
                r_a         <= bus.i_a_in;
                r_b         <= bus.i_b_in;
                r_rd        <= bus.i_rd_in;
                r_busy_seen <= 1'b0;
            end
            if (r_state == WAIT && bus.i_calc_busy) r_busy_seen <= 1'b1;
            if (r_state == WAIT && w_done) r_data <= {8'h00, bus.i_calc_y};
            else if (r_state == WAIT && w_timeout) r_data <= '1;
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.o_stall      = 1'b0;
        bus.o_calc_start = 1'b0;
        bus.o_wb_we      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.o_stall = bus.i_req;
                w_next      = bus.i_req ? START : IDLE;
            end
            START: begin
                bus.o_stall      = 1'b1;
                bus.o_calc_start = 1'b1;
                w_next           = WAIT;
            end
            WAIT: begin
                bus.o_stall = 1'b1;
                w_next      = (w_done || w_timeout) ? WB : WAIT;
            end
            WB: begin
                bus.o_wb_we = (r_rd != 5'd0);
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.o_calc_a  = r_a;
    assign bus.o_calc_b  = r_b;
    assign bus.o_wb_rd   = r_rd;
    assign bus.o_wb_data = r_data;
endmodule
